pattern_hit_detector: RTL
=========================

Name: pattern_hit_detector

Overview:
- Producer end of the hit interface: scans a symbol stream against a programmable PAT_LEN-symbol pattern.
- Emits a one-cycle hout pulse each time the last PAT_LEN accepted symbols equal the pattern.
- With each pulse it also reports the stream index of the match's first symbol and a running hit count.
- Sits between the string source and the position-reporting counter; its hout/pl semantics match that counter's.

Parameters:
SYM_W, 8, symbol width in bits
PAT_LEN, 4, pattern length in symbols (>=2)
IDX_W, 7, stream index width; index wraps modulo 2^IDX_W
CNT_W, 8, hit counter width; counter saturates

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
pl  input  1  stream restart: clears index, window fill, hit count and hout; pattern is kept
pat_wr  input  1  write one pattern symbol this cycle
pat_sym  input  SYM_W  pattern symbol; first written symbol = first pattern symbol
sym_valid  input  1  stream symbol present this cycle
sym  input  SYM_W  stream symbol
hout  output  1  one-cycle hit pulse
match_pos  output  IDX_W  index of first symbol of the most recent hit
match_cnt  output  CNT_W  number of hits since reset/pl, saturating at all-ones
pat_ready  output  1  full pattern loaded (state RUN)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state EMPTY; all outputs 0.
  - Pattern regs, window, idx, fill, pat_wr_cnt all 0.
- States:
  - EMPTY: no pattern symbol written.
  - LOAD: 1..PAT_LEN-1 symbols written.
  - RUN: full pattern loaded; pat_ready=1 only in RUN.
- pat_wr:
  - Writes pat_sym into pattern[pat_wr_cnt], then increments pat_wr_cnt.
  - EMPTY -> LOAD; LOAD -> RUN when the PAT_LEN-th symbol is written.
  - pat_wr in RUN restarts loading: the written symbol becomes pattern[0], pat_wr_cnt=1, state LOAD (RUN if PAT_LEN==1 is not allowed), fill cleared.
- sym_valid outside RUN: symbol ignored; idx does not advance.
- sym_valid in RUN:
  - Shift sym into the PAT_LEN-deep window; fill saturates at PAT_LEN.
  - The symbol's index is the current idx; idx <= idx+1, wrapping mod 2^IDX_W.
  - Hit condition, evaluated with the new window: fill_before >= PAT_LEN-1 and every window slot equals its pattern slot (oldest slot = pattern[0]).
- On a hit, at the next edge (latency 1 cycle after the completing symbol's edge):
  - hout=1 for exactly one cycle.
  - match_pos <= (symbol idx - (PAT_LEN-1)) mod 2^IDX_W.
  - match_cnt <= match_cnt+1 unless all-ones.
- Between hits: hout=0; match_pos holds the last value.
- Overlapping matches are detected; back-to-back hits give consecutive hout pulses.
- Gaps in sym_valid do not break a match; only accepted symbols count.
- Priority within one cycle: reset > pl > pat_wr > sym_valid.
  - pl+pat_wr: both take effect.
  - pat_wr+sym_valid: symbol dropped.
  - pl+sym_valid: symbol dropped, idx=0.
- pl clears hout even if a hit was pending. match_pos is not cleared by pl.
- Reset mid-load discards the partial pattern.

Decomposition:
- Package pattern_hit_pkg: state enum {EMPTY, LOAD, RUN}; default SYM_W/PAT_LEN/IDX_W/CNT_W constants.
- One sub-module, match_window: window shift register, fill counter and PAT_LEN-way comparator producing a combinational hit_now.
- FSM, idx, match_pos and match_cnt stay in the top.

Test Plan:
- Load "ABCA" (0x41,0x42,0x43,0x41), pl, stream "ABCABCA" -> hout pulses after idx 3 and idx 6; match_pos 0 then 3; match_cnt 2; pat_ready=1 from the 4th pat_wr.
- Stream before pattern complete (EMPTY/LOAD), then finish load, stream "ABCA" -> no earlier hits; single hit with match_pos 0, showing idx did not advance while unloaded.
- pl, 126 non-matching symbols, then "ABCA" at idx 126,127,0,1 -> match_pos 126 (wrap), match_cnt 1.
- Same cycle pat_wr+sym_valid and pl+sym_valid -> symbol dropped in both; pl case leaves idx 0, hout 0, match_cnt 0.
- reset low after 2 of 4 pat_wr -> pat_ready 0, state EMPTY, all outputs 0; 4 fresh pat_wr reach RUN.
- Pattern "AAAA", 300 'A' symbols with random sym_valid gaps -> hout on every accepted symbol from the 4th; match_cnt stops at 255.

Source files
------------

// File: rtl/pattern_hit_detector_pkg.sv
// Shared types and default sizes for the pattern hit detector.
package pattern_hit_pkg;

  localparam int SYM_W_DEF   = 8;
  localparam int PAT_LEN_DEF = 4;
  localparam int IDX_W_DEF   = 7;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/pattern_hit_detector_if.sv
// Stream, pattern-load and hit-report signals between the detector and its neighbours.
interface pattern_hit_detector_if
  import pattern_hit_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             pl;
  logic             pat_wr;
  logic [SYM_W-1:0] pat_sym;
  logic             sym_valid;
  logic [SYM_W-1:0] sym;
  logic             hout;
  logic [IDX_W-1:0] match_pos;
  logic [CNT_W-1:0] match_cnt;
  logic             pat_ready;

  // The detector is the producer of hit reports.
  modport master (
    input  pl, pat_wr, pat_sym, sym_valid, sym,
    output hout, match_pos, match_cnt, pat_ready
  );

  modport slave (
    output pl, pat_wr, pat_sym, sym_valid, sym,
    input  hout, match_pos, match_cnt, pat_ready
  );

endinterface

// File: rtl/pattern_hit_detector_match_window.sv
// Sliding window of the last PAT_LEN accepted symbols and its compare against the pattern.
module match_window
  import pattern_hit_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int PAT_LEN = PAT_LEN_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear_i,
  input  logic                            shift_i,
  input  logic [SYM_W-1:0]                sym_i,
  input  logic [PAT_LEN-1:0][SYM_W-1:0]   pattern_i,
  output logic                            hit_now_o
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0][SYM_W-1:0] win_q, win_d;
  logic [FILL_W-1:0]             fill_q, fill_d;
  logic                          shifted_q, shifted_d;

  // Slot 0 holds the oldest symbol so it lines up with pattern slot 0.
  always_comb begin
    win_d     = win_q;
    fill_d    = fill_q;
    shifted_d = 1'b0;
    if (clear_i) begin
      fill_d = '0;
    end else if (shift_i) begin
      for (int i = 0; i < PAT_LEN - 1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[PAT_LEN-1] = sym_i;
      if (fill_q != FILL_W'(PAT_LEN)) begin
        fill_d = fill_q + FILL_W'(1);
      end
      shifted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_q     <= '0;
      fill_q    <= '0;
      shifted_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      fill_q    <= fill_d;
      shifted_q <= shifted_d;
    end
  end

  // A full window only counts once, in the cycle right after the symbol that completed it.
  assign hit_now_o = shifted_q && (fill_q == FILL_W'(PAT_LEN)) && (win_q == pattern_i);

endmodule

// File: rtl/pattern_hit_detector.sv
// Programmable pattern matcher: loads a PAT_LEN-symbol pattern, then reports hits on the stream.
module pattern_hit_detector
  import pattern_hit_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  pattern_hit_detector_if.master  bus
);

  localparam int PW = $clog2(PAT_LEN + 1);

  state_e                        state_q, state_d;
  logic [PW-1:0]                 patWrCnt_q, patWrCnt_d;
  logic [PAT_LEN-1:0][SYM_W-1:0] pattern_q, pattern_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [IDX_W-1:0]              matchPos_q, matchPos_d;
  logic [CNT_W-1:0]              matchCnt_q, matchCnt_d;
  logic                          hout_q, hout_d;
  logic                          winShift, winClear, hitNow;

  match_window #(
    .SYM_W   (SYM_W),
    .PAT_LEN (PAT_LEN)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (winClear),
    .shift_i   (winShift),
    .sym_i     (bus.sym),
    .pattern_i (pattern_q),
    .hit_now_o (hitNow)
  );

  // idx_q has already moved past the completing symbol, hence the PAT_LEN offset.
  always_comb begin
    state_d    = state_q;
    patWrCnt_d = patWrCnt_q;
    pattern_d  = pattern_q;
    idx_d      = idx_q;
    matchPos_d = matchPos_q;
    matchCnt_d = matchCnt_q;
    hout_d     = 1'b0;
    winShift   = 1'b0;
    winClear   = bus.pl;

    if (hitNow && !bus.pl) begin
      hout_d     = 1'b1;
      matchPos_d = idx_q - IDX_W'(PAT_LEN);
      if (matchCnt_q != '1) begin
        matchCnt_d = matchCnt_q + CNT_W'(1);
      end
    end

    if (bus.pl) begin
      idx_d      = '0;
      matchCnt_d = '0;
    end

    if (bus.pat_wr) begin
      if (state_q == RUN) begin
        pattern_d[0] = bus.pat_sym;
        patWrCnt_d   = PW'(1);
        state_d      = LOAD;
        winClear     = 1'b1;
      end else begin
        for (int i = 0; i < PAT_LEN; i++) begin
          if (patWrCnt_q == PW'(i)) begin
            pattern_d[i] = bus.pat_sym;
          end
        end
        patWrCnt_d = patWrCnt_q + PW'(1);
        state_d    = (patWrCnt_q == PW'(PAT_LEN - 1)) ? RUN : LOAD;
      end
    end else if (!bus.pl && bus.sym_valid && state_q == RUN) begin
      winShift = 1'b1;
      idx_d    = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      patWrCnt_q <= '0;
      pattern_q  <= '0;
      idx_q      <= '0;
      matchPos_q <= '0;
      matchCnt_q <= '0;
      hout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      patWrCnt_q <= patWrCnt_d;
      pattern_q  <= pattern_d;
      idx_q      <= idx_d;
      matchPos_q <= matchPos_d;
      matchCnt_q <= matchCnt_d;
      hout_q     <= hout_d;
    end
  end

  assign bus.hout      = hout_q;
  assign bus.match_pos = matchPos_q;
  assign bus.match_cnt = matchCnt_q;
  assign bus.pat_ready = (state_q == RUN);

endmodule
